// File: rtl/spike_decoder_if.sv
// ---------------------------------------------------------------------------
// spike_decoder_if
//   Result channel between the spike decoder and the downstream
//   weight/accumulate logic.
//
//   Handshake: the producer raises out_valid with spike_time_out, fired and
//   code_err stable; they stay unchanged until a cycle where out_valid and
//   out_ready are both high, which is the single transfer point. out_ready
//   has no meaning while out_valid is low.
//
//   Signals:
//     out_valid       producer -> consumer  result available
//     out_ready       consumer -> producer  consumer accepts result
//     spike_time_out  producer -> consumer  N_LINES*TW, line i at [i*TW +: TW]
//     fired           producer -> consumer  line i was high at t=0
//     code_err        producer -> consumer  line i broke the leading-run code
// ---------------------------------------------------------------------------
interface spike_decoder_if #(
    parameter int N_LINES = 8,
    parameter int TW      = 4
);
    logic                  out_valid;
    logic                  out_ready;
    logic [N_LINES*TW-1:0] spike_time_out;
    logic [N_LINES-1:0]    fired;
    logic [N_LINES-1:0]    code_err;

    modport master (
        output out_valid,
        input  out_ready,
        output spike_time_out,
        output fired,
        output code_err
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  spike_time_out,
        input  fired,
        input  code_err
    );
endinterface

// File: rtl/spike_decoder.sv
// ---------------------------------------------------------------------------
// spike_decoder
//   Temporal-code receiver. Each line is expected to be high while
//   time_val < spike_time and low for the rest of a TIME_PERIOD window.
//   The block counts the leading high run of every line, flags lines whose
//   run is not contiguous (or spans the whole window), and presents the
//   decoded times on a valid/ready result channel.
//
//   Ports:
//     clk        clock
//     rst        asynchronous, active-high reset
//     start      begin a window (taken in IDLE, or in HOLD with out_ready)
//     spike_in   N_LINES sampled spike lines
//     time_val   current window time step, drives the upstream encoders
//     busy       high while collecting
//     state_dbg  current FSM state (0 IDLE, 1 COLLECT, 2 HOLD)
//     res        result channel (spike_decoder_if.master)
// ---------------------------------------------------------------------------
module spike_decoder #(
    parameter int N_LINES     = 8,
    parameter int TIME_PERIOD = 16,
    parameter int TW          = $clog2(TIME_PERIOD)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_LINES-1:0] spike_in,
    output logic [TW-1:0]      time_val,
    output logic               busy,
    output logic [1:0]         state_dbg,
    spike_decoder_if.master    res
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [TW-1:0] T_LAST   = TW'(TIME_PERIOD - 1);
    localparam logic [TW:0]   CNT_FULL = (TW + 1)'(TIME_PERIOD);

    state_t             state;
    logic [TW:0]        count [N_LINES];
    logic [N_LINES-1:0] run_open;
    logic [N_LINES-1:0] line_err;

    // Next-sample view of the per-line trackers; also feeds the result
    // registers so the final sample of the window is included.
    logic [TW:0]           cnt_nxt [N_LINES];
    logic [N_LINES-1:0]    open_nxt;
    logic [N_LINES-1:0]    err_nxt;
    logic [N_LINES*TW-1:0] sat_flat;
    logic [N_LINES-1:0]    fire_nxt;
    logic [N_LINES-1:0]    cerr_nxt;
    logic                  launch;

    assign state_dbg = state;

    // A new window starts from IDLE, or straight out of HOLD when the
    // result is taken in the same cycle (no idle bubble).
    assign launch = start && ((state == IDLE) ||
                              (state == HOLD && res.out_ready));

    always_comb begin
        open_nxt = run_open;
        err_nxt  = line_err;
        sat_flat = '0;
        fire_nxt = '0;
        cerr_nxt = '0;
        for (int i = 0; i < N_LINES; i++) begin
            cnt_nxt[i] = count[i];
            if (spike_in[i]) begin
                if (run_open[i]) begin
                    cnt_nxt[i] = count[i] + (TW + 1)'(1);
                end else begin
                    // High again after the run closed: not a leading run.
                    err_nxt[i] = 1'b1;
                end
            end else begin
                open_nxt[i] = 1'b0;
            end
            // A run covering the whole window cannot be encoded in TW bits.
            if (cnt_nxt[i] == CNT_FULL) begin
                sat_flat[i*TW +: TW] = T_LAST;
            end else begin
                sat_flat[i*TW +: TW] = cnt_nxt[i][TW-1:0];
            end
            cerr_nxt[i] = err_nxt[i] || (cnt_nxt[i] == CNT_FULL);
            fire_nxt[i] = (cnt_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            time_val           <= '0;
            busy               <= 1'b0;
            res.out_valid      <= 1'b0;
            res.spike_time_out <= '0;
            res.fired          <= '0;
            res.code_err       <= '0;
            run_open           <= '0;
            line_err           <= '0;
            for (int i = 0; i < N_LINES; i++) begin
                count[i] <= '0;
            end
        end else if (launch) begin
            state         <= COLLECT;
            busy          <= 1'b1;
            res.out_valid <= 1'b0;
            time_val      <= '0;
            run_open      <= '1;
            line_err      <= '0;
            for (int i = 0; i < N_LINES; i++) begin
                count[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    busy          <= 1'b0;
                    res.out_valid <= 1'b0;
                end
                COLLECT: begin
                    for (int i = 0; i < N_LINES; i++) begin
                        count[i] <= cnt_nxt[i];
                    end
                    run_open <= open_nxt;
                    line_err <= err_nxt;
                    if (time_val == T_LAST) begin
                        state              <= HOLD;
                        busy               <= 1'b0;
                        res.out_valid      <= 1'b1;
                        time_val           <= '0;
                        res.spike_time_out <= sat_flat;
                        res.fired          <= fire_nxt;
                        res.code_err       <= cerr_nxt;
                    end else begin
                        time_val <= time_val + TW'(1);
                    end
                end
                HOLD: begin
                    if (res.out_ready) begin
                        state         <= IDLE;
                        res.out_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    res.out_valid <= 1'b0;
                    time_val      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_decoder.sv
// ---------------------------------------------------------------------------
// tb_spike_decoder
//   Directed bench for spike_decoder with TIME_PERIOD=16, N_LINES=8.
//   Each window is described as one 16-bit pattern per line (bit t is the
//   sample at time t). The expected result is derived from the patterns
//   directly: length of the leading ones run, saturation, and whether any
//   one appears after the run ended. A single compare process checks every
//   DUT output against the expected values at each falling edge.
// ---------------------------------------------------------------------------
module tb_spike_decoder;

    localparam int N_LINES = 8;
    localparam int TP      = 16;
    localparam int TW      = 4;

    logic               clk;
    logic               rst;
    logic               start;
    logic [N_LINES-1:0] spike_in;
    logic [TW-1:0]      time_val;
    logic               busy;
    logic [1:0]         state_dbg;

    spike_decoder_if #(.N_LINES(N_LINES), .TW(TW)) sdif ();

    spike_decoder #(
        .N_LINES    (N_LINES),
        .TIME_PERIOD(TP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .spike_in (spike_in),
        .time_val (time_val),
        .busy     (busy),
        .state_dbg(state_dbg),
        .res      (sdif)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    logic [TP-1:0]         pat [N_LINES];
    logic [TW-1:0]         exp_tv;
    logic                  exp_busy;
    logic                  exp_valid;
    logic [N_LINES*TW-1:0] exp_st;
    logic [N_LINES-1:0]    exp_fired;
    logic [N_LINES-1:0]    exp_err;
    logic                  check_en;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result of one window, computed from the patterns.
    function automatic void model_window();
        int run;
        logic e;
        for (int i = 0; i < N_LINES; i++) begin
            run = 0;
            while (run < TP && pat[i][run]) run++;
            e = (run == TP);
            for (int t = run; t < TP; t++) if (pat[i][t]) e = 1'b1;
            exp_st[i*TW +: TW] = (run == TP) ? TW'(TP - 1) : TW'(run);
            exp_fired[i]       = (run != 0);
            exp_err[i]         = e;
        end
    endfunction

    function automatic void exp_reset();
        exp_tv    = '0;
        exp_busy  = 1'b0;
        exp_valid = 1'b0;
        exp_st    = '0;
        exp_fired = '0;
        exp_err   = '0;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("time_val",  32'(time_val),            32'(exp_tv));
            chk("busy",      32'(busy),                32'(exp_busy));
            chk("out_valid", 32'(sdif.out_valid),      32'(exp_valid));
            chk("spike_time",32'(sdif.spike_time_out), 32'(exp_st));
            chk("fired",     32'(sdif.fired),          32'(exp_fired));
            chk("code_err",  32'(sdif.code_err),       32'(exp_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_LINES-1:0] column(input int t);
        logic [N_LINES-1:0] c;
        for (int i = 0; i < N_LINES; i++) c[i] = pat[i][t];
        return c;
    endfunction

    // Called just after the edge that moved the DUT into COLLECT.
    // stop_t < TP aborts (returns) while time_val == stop_t, before its edge.
    task automatic collect(input int stop_t);
        start     = 1'b0;
        exp_busy  = 1'b1;
        exp_valid = 1'b0;
        for (int t = 0; t < TP; t++) begin
            exp_tv   = TW'(t);
            spike_in = column(t);
            if (t == stop_t) return;
            tick();
        end
        exp_busy  = 1'b0;
        exp_valid = 1'b1;
        exp_tv    = '0;
        model_window();
        spike_in  = N_LINES'($urandom_range(0, 255));
    endtask

    task automatic start_from_idle(input int stop_t);
        start = 1'b1;
        tick();
        collect(stop_t);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        check_en      = 1'b0;
        rst           = 1'b1;
        start         = 1'b0;
        spike_in      = '0;
        sdif.out_ready = 1'b0;
        exp_reset();
        for (int i = 0; i < N_LINES; i++) pat[i] = '0;
        #2 check_en = 1'b1;
        #10 rst = 1'b0;
        tick();

        // Window 1: basic decode.
        pat[0] = 16'h001F;
        pat[1] = 16'h0000;
        pat[2] = 16'h7FFF;
        start_from_idle(TP);
        chk("w1_st0",    32'(sdif.spike_time_out[3:0]),  32'd5);
        chk("w1_st1",    32'(sdif.spike_time_out[7:4]),  32'd0);
        chk("w1_st2",    32'(sdif.spike_time_out[11:8]), 32'd15);
        chk("w1_fired",  32'(sdif.fired),                32'h05);
        chk("w1_err",    32'(sdif.code_err),             32'h00);
        chk("w1_valid",  32'(sdif.out_valid),            32'd1);
        sdif.out_ready = 1'b1;
        tick();
        sdif.out_ready = 1'b0;
        exp_valid = 1'b0;
        tick();

        // Window 2: broken run, full-window run, late spike.
        pat[0] = 16'h0003;
        pat[1] = 16'h0000;
        pat[2] = 16'h0001;
        pat[3] = 16'h000B;
        pat[4] = 16'hFFFF;
        pat[5] = 16'h00FF;
        pat[6] = 16'h8000;
        pat[7] = 16'h0001;
        start_from_idle(TP);
        chk("w2_st3",    32'(sdif.spike_time_out[15:12]), 32'd2);
        chk("w2_err3",   32'(sdif.code_err[3]),           32'd1);
        chk("w2_st4",    32'(sdif.spike_time_out[19:16]), 32'd15);
        chk("w2_err4",   32'(sdif.code_err[4]),           32'd1);
        chk("w2_fired4", 32'(sdif.fired[4]),              32'd1);
        chk("w2_st6",    32'(sdif.spike_time_out[27:24]), 32'd0);
        chk("w2_err6",   32'(sdif.code_err[6]),           32'd1);
        chk("w2_err",    32'(sdif.code_err),              32'h58);

        // Window 3: chained start in HOLD (no bubble).
        for (int i = 0; i < N_LINES; i++) pat[i] = TP'((1 << (2 * i)) - 1);
        sdif.out_ready = 1'b1;
        start          = 1'b1;
        tick();
        sdif.out_ready = 1'b0;
        chk("w3_busy",   32'(busy),     32'd1);
        chk("w3_tv",     32'(time_val), 32'd0);
        collect(TP);
        chk("w3_st7",    32'(sdif.spike_time_out[31:28]), 32'd14);
        chk("w3_fired",  32'(sdif.fired),                 32'hFE);

        // Stall in HOLD with noisy inputs and start ignored-not-allowed.
        for (int k = 0; k < 5; k++) begin
            spike_in = N_LINES'($urandom_range(0, 255));
            tick();
        end
        sdif.out_ready = 1'b1;
        tick();
        sdif.out_ready = 1'b0;
        exp_valid = 1'b0;
        chk("w3_idle",   32'(state_dbg), 32'd0);
        tick();

        // Window 4: reset at time_val=7, out_ready high during COLLECT.
        for (int i = 0; i < N_LINES; i++) pat[i] = TP'($urandom_range(0, 65535));
        sdif.out_ready = 1'b1;
        start_from_idle(7);
        rst = 1'b1;
        exp_reset();
        #1;
        chk("rst_busy",  32'(busy),                32'd0);
        chk("rst_valid", 32'(sdif.out_valid),      32'd0);
        chk("rst_tv",    32'(time_val),            32'd0);
        chk("rst_st",    32'(sdif.spike_time_out), 32'd0);
        chk("rst_fired", 32'(sdif.fired),          32'd0);
        chk("rst_err",   32'(sdif.code_err),       32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Window 5: decode after reset; out_ready already high.
        pat[0] = 16'h0000;
        pat[1] = 16'h0001;
        pat[2] = 16'h0007;
        pat[3] = 16'h0FFF;
        pat[4] = 16'h0005;
        pat[5] = 16'hFFFE;
        pat[6] = 16'h3FFF;
        pat[7] = 16'h7FFF;
        start_from_idle(TP);
        chk("w5_st3",    32'(sdif.spike_time_out[15:12]), 32'd12);
        chk("w5_err",    32'(sdif.code_err),              32'h30);
        tick();
        exp_valid = 1'b0;
        sdif.out_ready = 1'b0;
        tick();
        tick();

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
